multi_slot_message_buffer: RTL and testbench
============================================

// Module: multi_slot_message_buffer
// PURPOSE
//  Next-generation bus-to-NoC message buffer. Collects Wishbone burst chunks into N_SLOTS message slots.
//  Closed messages leave in completion order through the existing msg_to_pkt converter, with a valid/ready handshake.
//  Sits between the wb slave interface and the NIC packet injection queues.
//  While earlier messages wait for the network, a new message can be accepted.
// PARAMETERS
//  N_BITS_VNET_ID       2   width of vnet_id_o
//  N_BITS_BURST_LENGHT  5   log2 bound on burst length; chunk counters are N_BITS_BURST_LENGHT+1 bits
//  N_SLOTS              4   message slots; power of 2, >=2
//  MAX_BURST  `MAX_BURST_LENGHT   chunks per message; must be <= 2**N_BITS_BURST_LENGHT
// PORTS
//  clk                              in   1    single clock, rising edge
//  rst                              in   1    reset: asynchronous, active-low (0 = reset)
//  ADR_I                            in   `BUS_ADDRESS_WIDTH  bus address; used from first chunk only
//  DAT_I                            in   `BUS_DATA_WIDTH     chunk data
//  SEL_I                            in   `BUS_SEL_WIDTH      chunk byte selects
//  WE_I                             in   1    write flag; latched with first chunk
//  reply_for_wb_master_interface_i  in   1    message is a reply; latched with first chunk
//  is_valid_i                       in   1    chunk valid
//  last_i                           in   1    qualified by is_valid_i; chunk closes the message
//  abort_i                          in   1    discard the partially filled message
//  in_ready_o                       out  1    chunk can be accepted this cycle
//  pkt_o                            out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet of head slot
//  vnet_id_o                        out  N_BITS_VNET_ID      pkt_o[`FLIT_VNET_ID_BITS] when is_valid_o, else 0
//  n_chunks_o                       out  N_BITS_BURST_LENGHT+1  chunk count of head slot
//  is_valid_o                       out  1    head slot holds a closed message
//  ready_i                          in   1    downstream accepts pkt_o
// BEHAVIOUR
//  - Reset values (async, rst=0):
//    - wr_ptr, rd_ptr, fill count, all slot full flags, all sel entries = 0.
//    - Outputs: is_valid_o=0, vnet_id_o=0, n_chunks_o=0, in_ready_o=1.
//  - Slots form a circular FIFO; wr_ptr is the filling slot, rd_ptr is the head.
//    Both wrap N_SLOTS-1 -> 0.
//  - in_ready_o = !full[wr_ptr] (combinational). A chunk is accepted when is_valid_i && in_ready_o.
//  - On an accepted chunk:
//    - data[wr_ptr][cnt] <= DAT_I; sel[wr_ptr][cnt] <= SEL_I; cnt <= cnt+1.
//    - If cnt==0, also latch ADR_I, WE_I and the reply flag.
//  - Close condition: accepted chunk with last_i=1, or accepted chunk making cnt+1==MAX_BURST.
//    - On close: full[wr_ptr]<=1, n_chunks[wr_ptr]<=cnt+1, cnt<=0, wr_ptr<=wr_ptr+1.
//  - Latency: closing chunk at edge t -> is_valid_o=1 after edge t if that slot is the head (1 cycle).
//  - Output handshake:
//    - is_valid_o = full[rd_ptr].
//    - pkt_o, n_chunks_o and vnet_id_o stay stable while is_valid_o && !ready_i.
//    - On is_valid_o && ready_i: full[rd_ptr]<=0, sel[rd_ptr][*]<=0, rd_ptr<=rd_ptr+1.
//  - Sel entries beyond n_chunks are always 0 (cleared on free), so msg_to_pkt sees unused chunks as empty.
//  - Simultaneous close and pop:
//    - Both occur in the same cycle.
//    - When N_SLOTS slots were full, in_ready_o is 0, so no close can coincide with all-full.
//    - Freeing makes in_ready_o 1 next cycle only when full[wr_ptr] clears (no combinational path from ready_i to in_ready_o).
//  - abort_i:
//    - cnt<=0 and a chunk presented in the same cycle is dropped.
//    - Closed slots are untouched; abort with cnt==0 is a no-op.
//    - abort takes priority over is_valid_i/last_i.
//  - last_i without is_valid_i is ignored.
//  - When in_ready_o=0, chunks are not accepted and state is unchanged; the sender must hold them.
//  - Reset mid-burst or mid-handshake drops every stored message immediately; there is no drain.
// STRUCTURE
//  - Constants (bus widths, `MAX_BURST_LENGHT, flit fields, `HEAD_TAIL_FLIT) stay in NIC-defines.v; no new globals.
//  - One sub-module: the existing msg_to_pkt, single instance on the head slot.
//    - Inputs: head slot fields, flattened data/sel arrays.
//    - r_msg2pkt_i = is_valid_o.
//  - Slot storage is a 2-D reg array indexed by slot and chunk. Pointers are $clog2(N_SLOTS) bits.
// TESTING
//  1. Single write, 1 chunk with last_i, ADR=0x100, DAT=0xA5A5A5A5, SEL=4'hF, ready_i=1
//     -> is_valid_o one cycle after; n_chunks_o=1; popped next edge.
//  2. Burst of MAX_BURST chunks, last_i=0 throughout -> auto close at chunk MAX_BURST; n_chunks_o=MAX_BURST; cnt returns to 0.
//  3. ready_i=0, N_SLOTS messages of 2 chunks each
//     -> in_ready_o=0 after the 4th close; pkt_o/vnet_id_o stable.
//     -> Raising ready_i pops in order (addresses 0x10,0x20,0x30,0x40).
//  4. abort_i after 3 chunks, then new 1-chunk message at 0x200 -> only 0x200 emitted, n_chunks_o=1, old sel entries 0.
//  5. Close slot 1 in the same cycle slot 0 pops -> both take effect; is_valid_o stays 1 and the next pkt is slot 1.
//  6. rst=0 asserted asynchronously mid-burst with 2 slots full
//     -> outputs 0 and in_ready_o=1 immediately; a fresh message after release is emitted normally.

Source files
------------

// File: rtl/multi_slot_message_buffer_pkg.sv
// Shared widths, flit layout and helpers for the multi-slot bus-to-NoC message buffer.
// Flit = {head/tail code, sel, data}; head flit = {head/tail code, vnet, we, reply, adr}.
package multi_slot_message_buffer_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;
    localparam int MAX_BURST_LENGHT  = 8;

    localparam int HT_W              = 2;
    localparam int VNET_W            = 2;
    localparam int FLIT_WIDTH        = HT_W + BUS_SEL_WIDTH + BUS_DATA_WIDTH;
    localparam int MAX_PACKET_LENGHT = MAX_BURST_LENGHT + 1;
    localparam int FLIT_VNET_ID_LSB  = BUS_ADDRESS_WIDTH + 2;

    localparam logic [HT_W-1:0] HT_BODY      = 2'b00;
    localparam logic [HT_W-1:0] HT_TAIL      = 2'b01;
    localparam logic [HT_W-1:0] HT_HEAD      = 2'b10;
    localparam logic [HT_W-1:0] HT_HEAD_TAIL = 2'b11;

    localparam logic [VNET_W-1:0] VNET_WR_REQ = 2'd0;
    localparam logic [VNET_W-1:0] VNET_RD_REQ = 2'd1;
    localparam logic [VNET_W-1:0] VNET_REPLY  = 2'd2;

    typedef struct packed {
        logic [BUS_ADDRESS_WIDTH-1:0] adr;
        logic                         we;
        logic                         reply;
    } slot_hdr_t;

    // Replies travel on their own vnet so they can never be blocked behind requests.
    function automatic logic [VNET_W-1:0] vnet_of(input logic we, input logic reply);
        return reply ? VNET_REPLY : (we ? VNET_WR_REQ : VNET_RD_REQ);
    endfunction

    function automatic logic [BUS_DATA_WIDTH-1:0] byte_mask(input logic [BUS_SEL_WIDTH-1:0] sel);
        logic [BUS_DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < BUS_SEL_WIDTH; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/multi_slot_message_buffer_msg_to_pkt.sv
// Packs one closed message (header + chunk arrays) into a flat NoC packet.
// Latency: combinational. Backpressure: none; output is all-zero while r_msg2pkt_i is low.
// Unselected bytes are zeroed, so chunks with sel==0 come out as empty flits.
module msg_to_pkt
    import multi_slot_message_buffer_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 5,
    parameter int MAX_BURST           = MAX_BURST_LENGHT
) (
    input  slot_hdr_t                                hdr_i,
    input  logic [N_BITS_BURST_LENGHT:0]             n_chunks_i,
    input  logic [MAX_BURST*BUS_DATA_WIDTH-1:0]      data_i,
    input  logic [MAX_BURST*BUS_SEL_WIDTH-1:0]       sel_i,
    input  logic                                     r_msg2pkt_i,
    output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0]  pkt_o
);

    localparam int CNT_W = N_BITS_BURST_LENGHT + 1;

    always_comb begin
        pkt_o = '0;
        if (r_msg2pkt_i) begin
            pkt_o[FLIT_WIDTH-1:0] = {((n_chunks_i == '0) ? HT_HEAD_TAIL : HT_HEAD),
                                     vnet_of(hdr_i.we, hdr_i.reply),
                                     hdr_i.we, hdr_i.reply, hdr_i.adr};
            for (int k = 0; k < MAX_BURST; k++) begin
                pkt_o[(k+1)*FLIT_WIDTH +: FLIT_WIDTH] = {
                    ((CNT_W'(k + 1) == n_chunks_i) ? HT_TAIL : HT_BODY),
                    sel_i[k*BUS_SEL_WIDTH +: BUS_SEL_WIDTH],
                    data_i[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
                        & byte_mask(sel_i[k*BUS_SEL_WIDTH +: BUS_SEL_WIDTH])};
            end
        end
    end

endmodule

// File: rtl/multi_slot_message_buffer.sv
// Collects Wishbone burst chunks into N_SLOTS message slots and emits closed messages in order as packets.
// Latency: closing chunk at edge t -> is_valid_o after edge t when that slot is the head.
// Backpressure: in_ready_o drops only when every slot holds a closed message; ready_i has no comb path to it.
module multi_slot_message_buffer
    import multi_slot_message_buffer_pkg::*;
#(
    parameter int N_BITS_VNET_ID      = 2,
    parameter int N_BITS_BURST_LENGHT = 5,
    parameter int N_SLOTS             = 4,
    parameter int MAX_BURST           = MAX_BURST_LENGHT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [BUS_ADDRESS_WIDTH-1:0]            ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]               DAT_I,
    input  logic [BUS_SEL_WIDTH-1:0]                SEL_I,
    input  logic                                    WE_I,
    input  logic                                    reply_for_wb_master_interface_i,
    input  logic                                    is_valid_i,
    input  logic                                    last_i,
    input  logic                                    abort_i,
    output logic                                    in_ready_o,
    output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_o,
    output logic [N_BITS_VNET_ID-1:0]               vnet_id_o,
    output logic [N_BITS_BURST_LENGHT:0]            n_chunks_o,
    output logic                                    is_valid_o,
    input  logic                                    ready_i
);

    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int CNT_W = N_BITS_BURST_LENGHT + 1;
    localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_SLOTS-1:0]        full_q, full_d;

    slot_hdr_t                 hdr_q      [N_SLOTS];
    logic [CNT_W-1:0]          n_chunks_q [N_SLOTS];
    logic [BUS_DATA_WIDTH-1:0] data_q     [N_SLOTS][MAX_BURST];
    logic [BUS_SEL_WIDTH-1:0]  sel_q      [N_SLOTS][MAX_BURST];

    logic                      accept;
    logic                      close;
    logic                      pop;
    logic [IDX_W-1:0]          wr_idx;

    logic [MAX_BURST*BUS_DATA_WIDTH-1:0] head_data;
    logic [MAX_BURST*BUS_SEL_WIDTH-1:0]  head_sel;

    // Closed messages are contiguous from rd_ptr, so the filling slot is full only when all are.
    assign in_ready_o = ~full_q[wr_ptr_q];
    assign is_valid_o = full_q[rd_ptr_q];
    assign accept     = is_valid_i & in_ready_o & ~abort_i;
    assign close      = accept & (last_i | (cnt_q == CNT_W'(MAX_BURST - 1)));
    assign pop        = is_valid_o & ready_i;
    assign wr_idx     = cnt_q[IDX_W-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (close) begin
            cnt_d            = '0;
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (pop) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    // Sel is cleared on free and on abort so stale chunks never reach the packet; a pop never
    // targets the filling slot while it is being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                hdr_q[s]      <= '0;
                n_chunks_q[s] <= '0;
                for (int c = 0; c < MAX_BURST; c++) begin
                    sel_q[s][c] <= '0;
                end
            end
        end else begin
            if (pop) begin
                for (int c = 0; c < MAX_BURST; c++) begin
                    sel_q[rd_ptr_q][c] <= '0;
                end
            end
            if (abort_i && (cnt_q != '0)) begin
                for (int c = 0; c < MAX_BURST; c++) begin
                    sel_q[wr_ptr_q][c] <= '0;
                end
            end
            if (accept) begin
                sel_q[wr_ptr_q][wr_idx] <= SEL_I;
                if (cnt_q == '0) begin
                    hdr_q[wr_ptr_q] <= {ADR_I, WE_I, reply_for_wb_master_interface_i};
                end
                if (close) begin
                    n_chunks_q[wr_ptr_q] <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[wr_ptr_q][wr_idx] <= DAT_I;
        end
    end

    always_comb begin
        head_data = '0;
        head_sel  = '0;
        for (int c = 0; c < MAX_BURST; c++) begin
            head_data[c*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = data_q[rd_ptr_q][c];
            head_sel[c*BUS_SEL_WIDTH +: BUS_SEL_WIDTH]    = sel_q[rd_ptr_q][c];
        end
    end

    msg_to_pkt #(
        .N_BITS_BURST_LENGHT (N_BITS_BURST_LENGHT),
        .MAX_BURST           (MAX_BURST)
    ) u_msg_to_pkt (
        .hdr_i       (hdr_q[rd_ptr_q]),
        .n_chunks_i  (n_chunks_q[rd_ptr_q]),
        .data_i      (head_data),
        .sel_i       (head_sel),
        .r_msg2pkt_i (is_valid_o),
        .pkt_o       (pkt_o)
    );

    assign n_chunks_o = is_valid_o ? n_chunks_q[rd_ptr_q] : '0;
    assign vnet_id_o  = is_valid_o ? N_BITS_VNET_ID'(pkt_o[FLIT_VNET_ID_LSB +: VNET_W]) : '0;

endmodule

// File: tb/tb_multi_slot_message_buffer.sv
// Scoreboard bench: a message-level model queues expected packets; a negedge monitor checks handshakes and packets.
module tb_multi_slot_message_buffer;
    import multi_slot_message_buffer_pkg::*;

    localparam int N_SLOTS = 4;
    localparam int MB      = MAX_BURST_LENGHT;
    localparam int PKT_W   = MAX_PACKET_LENGHT * FLIT_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       adr_i, dat_i;
    logic [3:0]        sel_i;
    logic              we_i, reply_i, vld_i, last_i, abort_i, ready_i;
    logic              in_ready_o, valid_o;
    logic [PKT_W-1:0]  pkt_o;
    logic [1:0]        vnet_o;
    logic [5:0]        n_o;

    always #5 clk = ~clk;

    multi_slot_message_buffer #(
        .N_BITS_VNET_ID (2),
        .N_BITS_BURST_LENGHT (5),
        .N_SLOTS (N_SLOTS),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk), .rst (rst),
        .ADR_I (adr_i), .DAT_I (dat_i), .SEL_I (sel_i), .WE_I (we_i),
        .reply_for_wb_master_interface_i (reply_i),
        .is_valid_i (vld_i), .last_i (last_i), .abort_i (abort_i),
        .in_ready_o (in_ready_o), .pkt_o (pkt_o), .vnet_id_o (vnet_o),
        .n_chunks_o (n_o), .is_valid_o (valid_o), .ready_i (ready_i)
    );

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic [5:0]       n;
        logic [1:0]       vnet;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          closed_n = 0;
    logic [31:0] p_adr;
    logic        p_we, p_rep;
    logic [31:0] p_dat[$];
    logic [3:0]  p_sel[$];

    task automatic chkw(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected packet from the message: head flit, one flit per chunk with unselected bytes zeroed, tail marked.
    function automatic exp_t build_exp();
        exp_t        e;
        logic [1:0]  vn;
        logic [31:0] m;
        int          n;
        n  = p_dat.size();
        vn = p_rep ? 2'd2 : (p_we ? 2'd0 : 2'd1);
        e.pkt = '0;
        e.pkt[FLIT_WIDTH-1:0] = {2'b10, vn, p_we, p_rep, p_adr};
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) m[b*8 +: 8] = p_sel[k][b] ? p_dat[k][b*8 +: 8] : 8'h00;
            e.pkt[(k+1)*FLIT_WIDTH +: FLIT_WIDTH] = {((k == n - 1) ? 2'b01 : 2'b00), p_sel[k], m};
        end
        e.n    = 6'(n);
        e.vnet = vn;
        return e;
    endfunction

    // Reference model: partial message, count of closed messages, FIFO of expected packets.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            closed_n = 0;
            p_dat.delete();
            p_sel.delete();
            exp_q.delete();
        end else begin
            automatic bit pop_m = (closed_n > 0) && ready_i;
            if (abort_i) begin
                p_dat.delete();
                p_sel.delete();
            end else if (vld_i && closed_n < N_SLOTS) begin
                if (p_dat.size() == 0) begin
                    p_adr = adr_i; p_we = we_i; p_rep = reply_i;
                end
                p_dat.push_back(dat_i);
                p_sel.push_back(sel_i);
                if (last_i || p_dat.size() == MB) begin
                    exp_q.push_back(build_exp());
                    p_dat.delete();
                    p_sel.delete();
                    closed_n++;
                end
            end
            if (pop_m) closed_n--;
        end
    end

    initial forever begin
        @(negedge clk);
        chkw("in_ready", PKT_W'(in_ready_o), PKT_W'(closed_n < N_SLOTS));
        chkw("is_valid", PKT_W'(valid_o), PKT_W'(closed_n > 0));
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pkt: got valid with %0h expected none at %0t", pkt_o, $time);
            end else begin
                chkw("pkt", pkt_o, exp_q[0].pkt);
                chkw("n_chunks", PKT_W'(n_o), PKT_W'(exp_q[0].n));
                chkw("vnet_id", PKT_W'(vnet_o), PKT_W'(exp_q[0].vnet));
                if (ready_i) void'(exp_q.pop_front());
            end
        end else begin
            chkw("idle_n_chunks", PKT_W'(n_o), '0);
            chkw("idle_vnet_id", PKT_W'(vnet_o), '0);
            chkw("idle_pkt", pkt_o, '0);
        end
    end

    task automatic drive(input logic v, input logic l, input logic a, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we,
                         input logic rp, input logic rdy);
        vld_i = v; last_i = l; abort_i = a; adr_i = adr; dat_i = dat;
        sel_i = sel; we_i = we; reply_i = rp; ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        rst = 1'b0;
        vld_i = 0; last_i = 0; abort_i = 0; adr_i = 0; dat_i = 0;
        sel_i = 0; we_i = 0; reply_i = 0; ready_i = 0;
        #1;
        chkw("reset_in_ready", PKT_W'(in_ready_o), PKT_W'(1));
        chkw("reset_is_valid", PKT_W'(valid_o), '0);
        chkw("reset_n_chunks", PKT_W'(n_o), '0);
        chkw("reset_vnet_id", PKT_W'(vnet_o), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single 1-chunk write
        drive(1, 1, 0, 32'h100, 32'hA5A5A5A5, 4'hF, 1, 0, 1);
        idle(1, 2);

        // full burst without last_i closes itself
        for (int i = 0; i < MB; i++) drive(1, 0, 0, 32'h300 + i, 32'h1000 + i, 4'hF, 0, 0, 1);
        idle(1, 2);

        // fill every slot while blocked, try one more, then drain in order
        for (int m = 0; m < N_SLOTS; m++) begin
            drive(1, 0, 0, 32'(16 * (m + 1)), 32'hC0DE0000 + m, 4'hF, 1, 0, 0);
            drive(1, 1, 0, 32'h0, 32'hBEEF0000 + m, 4'h5, 1, 0, 0);
        end
        drive(1, 1, 0, 32'h50, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        idle(0, 3);
        idle(1, 6);

        // abort after three chunks; the aborting cycle's chunk is dropped
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'h180, 32'hFFFF0000 + i, 4'hF, 1, 0, 1);
        drive(1, 1, 1, 32'h190, 32'h77777777, 4'hF, 1, 0, 1);
        drive(1, 1, 0, 32'h200, 32'h12345678, 4'h3, 1, 0, 1);
        idle(1, 2);

        // close of the second slot coincides with pop of the first
        drive(1, 1, 0, 32'h500, 32'h55555555, 4'hF, 0, 1, 0);
        drive(1, 0, 0, 32'h600, 32'h66666666, 4'hC, 0, 0, 0);
        drive(1, 1, 0, 32'h0,   32'h66660001, 4'hF, 0, 0, 1);
        idle(1, 3);

        // asynchronous reset mid-burst with two slots full
        drive(1, 1, 0, 32'h700, 32'h70, 4'hF, 1, 0, 0);
        drive(1, 1, 0, 32'h710, 32'h71, 4'hF, 1, 0, 0);
        drive(1, 0, 0, 32'h720, 32'h72, 4'hF, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chkw("async_rst_in_ready", PKT_W'(in_ready_o), PKT_W'(1));
        chkw("async_rst_is_valid", PKT_W'(valid_o), '0);
        chkw("async_rst_n_chunks", PKT_W'(n_o), '0);
        chkw("async_rst_vnet_id", PKT_W'(vnet_o), '0);
        chkw("async_rst_pkt", pkt_o, '0);
        idle(0, 2);
        rst = 1'b1;
        drive(1, 1, 0, 32'h800, 32'h80808080, 4'h9, 0, 0, 1);
        idle(1, 2);

        // randomized traffic with alternating light/heavy backpressure
        for (int c = 0; c < 3000; c++) begin
            automatic logic rdy = ((c / 200) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            drive($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(19) == 0,
                  $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), rdy);
        end
        idle(1, 2 * N_SLOTS + 4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending packets expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
